// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with MTHI/MTLO writes.
// Optional abort input 'cancel' is compiled in when MULDIV_CANCEL_EN is defined.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_t;

    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [2*WIDTH-1:0] prod_r, prod_s;
    logic [WIDTH-1:0]   rem_r, rem_s;
    logic [WIDTH-1:0]   quo_r, quo_s;
    logic [WIDTH-1:0]   dvs_r, dvs_s;
    logic               qneg_r, qneg_s;
    logic               rneg_r, rneg_s;
    logic [WIDTH-1:0]   hi_s, lo_s;
    logic               done_s;
    logic               cancel_s;

    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_abs_s, b_abs_s;
    logic [2*WIDTH-1:0] a_ext_s, b_ext_s, mul_s;
    logic [WIDTH:0]     sh_s;
    logic               ge_s;

`ifdef MULDIV_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    // Sign/magnitude preparation; a sign-extended 2W-bit product equals the signed product.
    assign a_neg_s = ~op[0] & a[WIDTH-1];
    assign b_neg_s = ~op[0] & b[WIDTH-1];
    assign a_abs_s = a_neg_s ? -a : a;
    assign b_abs_s = b_neg_s ? -b : b;
    assign a_ext_s = {{WIDTH{a_neg_s}}, a};
    assign b_ext_s = {{WIDTH{b_neg_s}}, b};
    assign mul_s   = a_ext_s * b_ext_s;

    // One restoring step: the shifted remainder needs WIDTH+1 bits for the compare only.
    assign sh_s = {rem_r, quo_r[WIDTH-1]};
    assign ge_s = (sh_s >= {1'b0, dvs_r});

    assign busy = (state_r != IDLE);

    // Next-state and datapath update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        prod_s  = prod_r;
        rem_s   = rem_r;
        quo_s   = quo_r;
        dvs_s   = dvs_r;
        qneg_s  = qneg_r;
        rneg_s  = rneg_r;
        hi_s    = hi;
        lo_s    = lo;
        done_s  = 1'b0;
        if (cancel_s && (state_r != IDLE)) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (hi_we) hi_s = wdata;
                    else       hi_s = hi;
                    if (lo_we) lo_s = wdata;
                    else       lo_s = lo;
                    if (start && !cancel_s) begin
                        cnt_s = {CW{1'b0}};
                        if (!op[1]) begin
                            state_s = MUL;
                            prod_s  = mul_s;
                        end else if (b != {WIDTH{1'b0}}) begin
                            state_s = DIV;
                            quo_s   = a_abs_s;
                            dvs_s   = b_abs_s;
                            rem_s   = {WIDTH{1'b0}};
                            qneg_s  = a_neg_s ^ b_neg_s;
                            rneg_s  = a_neg_s;
                        end else begin
                            // Divide by zero skips iteration: LO = all ones, HI = dividend.
                            state_s = FIX;
                            quo_s   = {WIDTH{1'b1}};
                            rem_s   = a;
                            qneg_s  = 1'b0;
                            rneg_s  = 1'b0;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                MUL: begin
                    if (cnt_r == MUL_LAST) begin
                        hi_s    = prod_r[2*WIDTH-1:WIDTH];
                        lo_s    = prod_r[WIDTH-1:0];
                        done_s  = 1'b1;
                        state_s = IDLE;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                DIV: begin
                    rem_s = ge_s ? (sh_s[WIDTH-1:0] - dvs_r) : sh_s[WIDTH-1:0];
                    quo_s = {quo_r[WIDTH-2:0], ge_s};
                    if (cnt_r == DIV_LAST) begin
                        state_s = FIX;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                FIX: begin
                    lo_s    = qneg_r ? -quo_r : quo_r;
                    hi_s    = rneg_r ? -rem_r : rem_r;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and architectural HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            prod_r  <= prod_s;
            rem_r   <= rem_s;
            quo_r   <= quo_s;
            dvs_r   <= dvs_s;
            qneg_r  <= qneg_s;
            rneg_r  <= rneg_s;
            hi      <= hi_s;
            lo      <= lo_s;
            done    <= done_s;
        end
    end

endmodule
